// File: rtl/tx_cpu_writer.sv
// tx_cpu_writer
// Packetizes Avalon-MM register writes from the HPS into a 64-bit packet
// stream feeding the CPU side of the TX buffer. Two 32-bit writes form one
// beat (WORD0 then WORD1, where WORD1 commits). A CTRL write arms EOP and the
// empty-byte count for the next commit. Packets that reach MAX_BEATS are cut
// with a forced EOP. The rest of that packet is then dropped until the CPU's
// own EOP commit.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   amm_address_i       0 WORD0, 1 WORD1, 2 CTRL, 3 STATUS
//   amm_write_i         write strobe, with amm_writedata_i
//   amm_read_i          read strobe; amm_readdata_o is valid one cycle later
//   amm_waitrequest_o   stalls a WORD1 write while the output beat is blocked
//   pkt_data_o          beat data, byte 0 in [63:56]
//   pkt_sop_o/eop_o     packet delimiters
//   pkt_mod_o           empty bytes in the EOP beat
//   pkt_val_o           beat valid
//   pkt_ready_i         downstream ready
module tx_cpu_writer #(
  parameter int unsigned MAX_BEATS = 190,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  amm_address_i,
  input  logic        amm_write_i,
  input  logic [31:0] amm_writedata_i,
  input  logic        amm_read_i,
  output logic [31:0] amm_readdata_o,
  output logic        amm_waitrequest_o,
  output logic [63:0] pkt_data_o,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic [2:0]  pkt_mod_o,
  output logic        pkt_val_o,
  input  logic        pkt_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [31:0]      word0;
  logic [2:0]       mod;
  logic             eop_arm;
  logic             ovf;
  logic [15:0]      beat_cnt, beat_cnt_next;
  logic [16:0]      beat_inc;
  logic [CNT_W-1:0] pkt_cnt;
  logic [31:0]      cnt_ext;
  logic [31:0]      rd_mux;

  logic wr_word0, wr_word1, wr_ctrl;
  logic commit, drain;
  logic emit, emit_sop, emit_eop, set_ovf;
  logic [2:0] emit_mod;
  logic unused_bits;

  assign wr_word0 = amm_write_i && (amm_address_i == 2'd0);
  assign wr_word1 = amm_write_i && (amm_address_i == 2'd1);
  assign wr_ctrl  = amm_write_i && (amm_address_i == 2'd2);

  // Discarded commits never load the holding register, so they are never stalled.
  assign amm_waitrequest_o = wr_word1 && pkt_val_o && !pkt_ready_i && (state != ST_DISCARD);
  assign commit = wr_word1 && !amm_waitrequest_o;
  assign drain  = pkt_val_o && pkt_ready_i;

  assign beat_inc = {1'b0, beat_cnt} + 17'd1;

  // Next state and the beat to emit, assuming a commit happens this cycle.
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    emit          = 1'b0;
    emit_sop      = 1'b0;
    emit_eop      = 1'b0;
    emit_mod      = 3'd0;
    set_ovf       = 1'b0;
    case (state)
      ST_IDLE: begin
        emit     = 1'b1;
        emit_sop = 1'b1;
        if (eop_arm) begin
          emit_eop = 1'b1;
          emit_mod = mod;
        end else begin
          beat_cnt_next = 16'd1;
          state_next    = ST_PKT;
        end
      end
      ST_PKT: begin
        emit          = 1'b1;
        beat_cnt_next = beat_inc[15:0];
        if (eop_arm) begin
          emit_eop   = 1'b1;
          emit_mod   = mod;
          state_next = ST_IDLE;
        end else if (beat_inc == 17'(MAX_BEATS)) begin
          // Truncate an over-length packet: forced EOP with no empty bytes.
          emit_eop   = 1'b1;
          set_ovf    = 1'b1;
          state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (eop_arm) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control registers. A CTRL write takes priority over the post-commit
  // clear, so it lands after any commit in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      word0    <= '0;
      mod      <= '0;
      eop_arm  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (commit) begin
        state    <= state_next;
        beat_cnt <= beat_cnt_next;
      end
      if (wr_word0) word0 <= amm_writedata_i;
      if (wr_ctrl) begin
        mod     <= amm_writedata_i[2:0];
        eop_arm <= amm_writedata_i[3];
      end else if (commit) begin
        mod     <= '0;
        eop_arm <= 1'b0;
      end
      // A new overflow beats a simultaneous clear.
      if (commit && set_ovf)                   ovf <= 1'b1;
      else if (wr_ctrl && amm_writedata_i[8])  ovf <= 1'b0;
    end
  end

  // Single holding register. A load replaces the drained beat in the same
  // cycle, which sustains one beat per clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_val_o  <= 1'b0;
      pkt_data_o <= '0;
      pkt_sop_o  <= 1'b0;
      pkt_eop_o  <= 1'b0;
      pkt_mod_o  <= '0;
    end else if (commit && emit) begin
      pkt_val_o  <= 1'b1;
      pkt_data_o <= {word0, amm_writedata_i};
      pkt_sop_o  <= emit_sop;
      pkt_eop_o  <= emit_eop;
      pkt_mod_o  <= emit_mod;
    end else if (drain) begin
      pkt_val_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               pkt_cnt <= '0;
    else if (drain && pkt_eop_o) pkt_cnt <= pkt_cnt + CNT_W'(1);
  end

  assign cnt_ext = 32'(pkt_cnt);

  always_comb begin
    rd_mux = '0;
    case (amm_address_i)
      2'd2: rd_mux = {23'b0, ovf, 4'b0, eop_arm, mod};
      2'd3: rd_mux = {cnt_ext[15:0], 12'b0, ovf, 2'(state), pkt_val_o};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        amm_readdata_o <= '0;
    else if (amm_read_i) amm_readdata_o <= rd_mux;
  end

  assign unused_bits = ^{amm_writedata_i[31:9], amm_writedata_i[7:4], cnt_ext[31:16], beat_inc[16]};

endmodule

// File: tb/tb_tx_cpu_writer.sv
// tb_tx_cpu_writer
// Self-checking bench for tx_cpu_writer, built with MAX_BEATS=4 and CNT_W=2
// so that truncation and counter wrap are reachable quickly. A packet-level
// reference model runs on every falling edge. It checks valid, waitrequest,
// readdata and each beat against a queue of expected beats. Directed table
// vectors and hand-written sequences come first, then randomized bus traffic.
module tb_tx_cpu_writer;

  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  amm_address;
  logic        amm_write;
  logic [31:0] amm_writedata;
  logic        amm_read;
  logic [31:0] amm_readdata;
  logic        amm_waitrequest;
  logic [63:0] pkt_data;
  logic        pkt_sop, pkt_eop, pkt_val;
  logic [2:0]  pkt_mod;
  logic        pkt_ready;
  logic        ready_manual;
  logic        ready_rand = 1'b1;
  logic        rand_mode;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  beat_t       mq[$];
  logic [31:0] m_word0;
  logic [2:0]  m_mod;
  logic        m_eop_arm, m_ovf, m_discard;
  int          m_beats;
  int          m_cnt;
  logic [31:0] m_rd;

  // Observations of completed handshakes, for the hand-written checks.
  int    hs_count = 0;
  beat_t last_beat = '0;

  always #5 clk = ~clk;

  assign pkt_ready = rand_mode ? ready_rand : ready_manual;

  tx_cpu_writer #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .amm_address_i     (amm_address),
    .amm_write_i       (amm_write),
    .amm_writedata_i   (amm_writedata),
    .amm_read_i        (amm_read),
    .amm_readdata_o    (amm_readdata),
    .amm_waitrequest_o (amm_waitrequest),
    .pkt_data_o        (pkt_data),
    .pkt_sop_o         (pkt_sop),
    .pkt_eop_o         (pkt_eop),
    .pkt_mod_o         (pkt_mod),
    .pkt_val_o         (pkt_val),
    .pkt_ready_i       (pkt_ready)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one bus operation starting just after a rising edge. Writes to
  // WORD1 are held while waitrequest is high, with a bounded wait.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] addr,
                               input logic [31:0] data, output int stalls);
    bit done;
    amm_address   = addr;
    amm_write     = wr;
    amm_read      = rd;
    amm_writedata = data;
    stalls = 0;
    done   = 1'b0;
    while (!done && stalls < 200) begin
      @(negedge clk);
      if (wr && amm_waitrequest) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_timeout: got %0d stall cycles, expected fewer than 200", stalls);
    end
    @(posedge clk);
    #1;
    amm_write = 1'b0;
    amm_read  = 1'b0;
  endtask

  task automatic doWrite(input logic [1:0] addr, input logic [31:0] data, output int stalls);
    applyStimulus(1'b1, 1'b0, addr, data, stalls);
  endtask

  task automatic doRead(input logic [1:0] addr, output logic [31:0] value);
    int s;
    applyStimulus(1'b0, 1'b1, addr, 32'h0, s);
    value = amm_readdata;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet-level model: checks current outputs first, then applies this
  // cycle's read, handshake and write as they will land at the next edge.
  always @(negedge clk) begin : model
    beat_t       b;
    logic        exp_val, exp_wait;
    logic [31:0] wd;
    if (!rst_n) begin
      mq.delete();
      m_word0   = '0;
      m_mod     = '0;
      m_eop_arm = 1'b0;
      m_ovf     = 1'b0;
      m_discard = 1'b0;
      m_beats   = 0;
      m_cnt     = 0;
      m_rd      = '0;
    end else begin
      exp_val  = (mq.size() != 0);
      exp_wait = amm_write && (amm_address == 2'd1) && exp_val && !pkt_ready && !m_discard;
      checkOutput("pkt_val", 128'(pkt_val), 128'(exp_val));
      checkOutput("waitrequest", 128'(amm_waitrequest), 128'(exp_wait));
      checkOutput("readdata", 128'(amm_readdata), 128'(m_rd));
      if (exp_val && pkt_val)
        checkOutput("beat", 128'({pkt_data, pkt_sop, pkt_eop, pkt_mod}), 128'(mq[0]));

      if (pkt_val && pkt_ready) begin
        hs_count++;
        last_beat = {pkt_data, pkt_sop, pkt_eop, pkt_mod};
      end

      if (amm_read) begin
        case (amm_address)
          2'd2: m_rd = {23'b0, m_ovf, 4'b0, m_eop_arm, m_mod};
          2'd3: m_rd = {16'(m_cnt), 12'b0, m_ovf,
                        m_discard ? 2'd2 : ((m_beats != 0) ? 2'd1 : 2'd0), exp_val};
          default: m_rd = '0;
        endcase
      end

      if (exp_val && pkt_ready) begin
        b = mq.pop_front();
        if (b.eop) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end

      if (amm_write && !exp_wait) begin
        wd = amm_writedata;
        case (amm_address)
          2'd0: m_word0 = wd;
          2'd1: begin
            if (m_discard) begin
              if (m_eop_arm) m_discard = 1'b0;
            end else begin
              b.data = {m_word0, wd};
              b.sop  = (m_beats == 0);
              m_beats++;
              if (m_eop_arm) begin
                b.eop = 1'b1;
                b.mod = m_mod;
                m_beats = 0;
              end else if (m_beats == MAX_BEATS) begin
                b.eop = 1'b1;
                b.mod = 3'd0;
                m_ovf = 1'b1;
                m_discard = 1'b1;
                m_beats = 0;
              end else begin
                b.eop = 1'b0;
                b.mod = 3'd0;
              end
              mq.push_back(b);
            end
            m_eop_arm = 1'b0;
            m_mod     = '0;
          end
          2'd2: begin
            m_mod     = wd[2:0];
            m_eop_arm = wd[3];
            if (wd[8]) m_ovf = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Random downstream ready, only used during the randomized phase.
  always @(posedge clk) begin
    #1;
    ready_rand = ($urandom_range(0, 3) != 0);
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t        vecs[13];
    logic [31:0] v;
    int          s, total, hs0;

    vecs[0]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
    vecs[1]  = '{1'b1, 2'd2, 32'h0000_000B, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0000_000B};
    vecs[3]  = '{1'b1, 2'd0, 32'h0011_2233, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
    vecs[5]  = '{1'b1, 2'd1, 32'h4455_6677, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 32'h0,        32'h0000_0000};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0001_0000};
    vecs[8]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0000};
    vecs[9]  = '{1'b1, 2'd2, 32'h0000_010D, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0000_000D};
    vecs[11] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 32'h0,        32'h0000_0000};

    rst_n = 1'b0;
    amm_address = '0;
    amm_write = 1'b0;
    amm_read = 1'b0;
    amm_writedata = '0;
    ready_manual = 1'b1;
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_val", 128'(pkt_val), 128'(0));
    checkOutput("reset_readdata", 128'(amm_readdata), 128'(0));

    // Table vectors: single-beat packet and register readback.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) doWrite(vecs[i].addr, vecs[i].data, s);
      else begin
        doRead(vecs[i].addr, v);
        checkOutput($sformatf("vec%0d_read", i), 128'(v), 128'(vecs[i].exp_rd));
      end
    end
    checkOutput("single_beat", 128'(last_beat),
                128'(beat_t'{64'h0011_2233_4455_6677, 1'b1, 1'b1, 3'd3}));

    // Three-beat packet with ready held low for five cycles.
    hs0 = hs_count;
    ready_manual = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        ready_manual = 1'b1;
      end
    join_none
    doWrite(2'd0, 32'h1111_1111, s);
    doWrite(2'd1, 32'h2222_2222, s);
    doWrite(2'd0, 32'h3333_3333, s);
    doWrite(2'd1, 32'h4444_4444, s);
    checkOutput("stall_cycles", 128'(s), 128'(2));
    doWrite(2'd2, 32'h0000_0008, s);
    doWrite(2'd0, 32'h5555_5555, s);
    doWrite(2'd1, 32'h6666_6666, s);
    idleCycles(3);
    checkOutput("three_beat_count", 128'(hs_count - hs0), 128'(3));
    checkOutput("three_beat_last", 128'({last_beat.sop, last_beat.eop, last_beat.mod}), 128'(5'b01000));

    // Back-to-back commits with ready high: one beat per clock, no stalls.
    total = 0;
    for (int i = 0; i < 3; i++) begin
      doWrite(2'd1, 32'hB2B0_0000 + 32'(i), s);
      total += s;
      checkOutput("b2b_val", 128'(pkt_val), 128'(1));
    end
    checkOutput("b2b_stalls", 128'(total), 128'(0));
    idleCycles(1);
    checkOutput("b2b_drained", 128'(pkt_val), 128'(0));
    doWrite(2'd2, 32'h0000_0008, s);
    doWrite(2'd1, 32'hB2B0_00FF, s);
    idleCycles(2);

    // Overflow: the fourth non-EOP beat is forced to EOP with mod 0.
    hs0 = hs_count;
    doWrite(2'd1, 32'h0F00_0001, s);
    doWrite(2'd1, 32'h0F00_0002, s);
    doWrite(2'd1, 32'h0F00_0003, s);
    doWrite(2'd2, 32'h0000_0005, s);
    doWrite(2'd1, 32'h0F00_0004, s);
    idleCycles(1);
    doRead(2'd3, v);
    checkOutput("ovf_status_discard", 128'(v & 32'hE), 128'(32'hC));
    doWrite(2'd1, 32'h0F00_0005, s);
    doWrite(2'd1, 32'h0F00_0006, s);
    doWrite(2'd2, 32'h0000_0008, s);
    doWrite(2'd1, 32'h0F00_0007, s);
    doRead(2'd3, v);
    checkOutput("ovf_status_idle", 128'(v & 32'hE), 128'(32'h8));
    checkOutput("ovf_beats", 128'(hs_count - hs0), 128'(4));
    checkOutput("ovf_last_beat", 128'({last_beat.sop, last_beat.eop, last_beat.mod}), 128'(5'b01000));
    doWrite(2'd2, 32'h0000_0100, s);
    doRead(2'd3, v);
    checkOutput("ovf_cleared", 128'(v & 32'hE), 128'(0));

    // Asynchronous reset while a beat is held mid-packet.
    ready_manual = 1'b0;
    doWrite(2'd0, 32'hA5A5_A5A5, s);
    doWrite(2'd1, 32'h5A5A_5A5A, s);
    doRead(2'd3, v);
    checkOutput("pre_reset_status", 128'(v & 32'hF), 128'(32'h3));
    rst_n = 1'b0;
    #1;
    checkOutput("async_val", 128'(pkt_val), 128'(0));
    checkOutput("async_fields", 128'({pkt_data, pkt_sop, pkt_eop, pkt_mod}), 128'(0));
    checkOutput("async_readdata", 128'(amm_readdata), 128'(0));
    checkOutput("async_waitreq", 128'(amm_waitrequest), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_manual = 1'b1;
    doRead(2'd3, v);
    checkOutput("post_reset_status", 128'(v), 128'(0));

    // Five single-beat packets wrap the 2-bit packet counter to 1.
    for (int i = 0; i < 5; i++) begin
      doWrite(2'd2, 32'h0000_000B, s);
      doWrite(2'd1, 32'hC0DE_0000 + 32'(i), s);
      if (i == 0) begin
        idleCycles(1);
        checkOutput("post_reset_sop", 128'(last_beat.sop), 128'(1));
      end
    end
    idleCycles(2);
    doRead(2'd3, v);
    checkOutput("count_wrap", 128'(v), 128'(32'h0001_0000));

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1:       idleCycles(1);
        2, 3, 4, 5: doWrite(2'd1, $urandom, s);
        6:          doWrite(2'd0, $urandom, s);
        7:          doWrite(2'd2, $urandom, s);
        8:          doRead(2'($urandom_range(0, 3)), v);
        default:    doWrite(2'd3, $urandom, s);
      endcase
    end
    rand_mode = 1'b0;
    ready_manual = 1'b1;
    idleCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
